adc_dump_tx: RTL and testbench
==============================

ADC_DUMP_TX -- requirements
Module: adc_dump_tx

Interface
Parameters (name, default, meaning):
REQ-001 CLK_FREQ, 50_000_000, clk frequency in Hz.
REQ-002 BAUD, 115200, UART bit rate.
REQ-003 ADDR_W, 10, capture-buffer address width; buffer depth = 2**ADDR_W.
REQ-004 DATA_W, 12, sample width; legal range is 9..16.

Ports (name, direction, width, meaning):
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 areset  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  level from the capture writer's wr_end; a rising edge requests one dump.
REQ-008 rd_addr  out  ADDR_W  capture-buffer read address.
REQ-009 rd_en  out  1  read strobe, one cycle per sample.
REQ-010 rd_data  in  DATA_W  buffer data, valid exactly 1 cycle after rd_en.
REQ-011 tx  out  1  UART 8N1 serial output; idles high.
REQ-012 busy  out  1  high from the accepted start edge until the last stop bit ends.
REQ-013 done  out  1  single-cycle pulse after the last stop bit.

Function
REQ-014 Detect the start rising edge with a registered copy of start; the edge is ignored while busy=1.
REQ-015 Frame format, in order:
- header byte 0xA5;
- per sample, address 0 to 2**ADDR_W-1: high byte {zero-pad, rd_data[DATA_W-1:8]}, then low byte rd_data[7:0].
REQ-016 Total frame length is 1 + 2*2**ADDR_W bytes (2049 with the defaults).
REQ-017 FSM states: IDLE, HDR, RD_REQ, RD_WAIT, SEND_HI, SEND_LO, NEXT, FIN.
REQ-018 Transitions:
- IDLE -> HDR on an accepted edge;
- HDR -> RD_REQ when the header byte completes;
- RD_REQ (rd_en=1 for one cycle) -> RD_WAIT;
- RD_WAIT latches rd_data into a sample register -> SEND_HI;
- SEND_HI -> SEND_LO when its byte completes;
- SEND_LO -> NEXT when its byte completes;
- NEXT -> RD_REQ with address+1, or -> FIN if the address was the last one;
- FIN pulses done for one cycle -> IDLE.
REQ-019 rd_addr holds its value from RD_REQ through SEND_LO, never wraps within a frame, and returns to 0 in FIN.
REQ-020 Only the latched sample register is transmitted; changes on rd_data after RD_WAIT have no effect.
REQ-021 Bit period CLKS_PER_BIT = (CLK_FREQ + BAUD/2) / BAUD, i.e. rounded to nearest (434 with the defaults).
REQ-022 Each byte is start bit 0, eight data bits LSB first, then stop bit 1, each held CLKS_PER_BIT cycles.
REQ-023 Bytes are sent back-to-back apart from the sample-fetch gap, which is at most 3 idle-high cycles.
REQ-024 A start edge that arrives during a dump is dropped, not queued; a level already high when the dump ends does not retrigger it.

Reset
REQ-025 While areset=1, asynchronously:
- tx=1, busy=0, done=0, rd_en=0, rd_addr=0;
- FSM in IDLE, bit and baud counters 0;
- edge register loaded with the current start value.
REQ-026 Reset mid-byte aborts the frame immediately; tx returns high with no partial stop bit.
REQ-027 After reset release, the next dump requires a fresh start rising edge.

Structure
REQ-028 A shared package holds:
- FSM state enum;
- HDR_BYTE = 8'hA5;
- CLKS_PER_BIT calculation function.
REQ-029 The UART byte serializer is the sub-module uart_byte_tx (ports tx_go, tx_byte[7:0], tx_busy, tx_done, tx). adc_dump_tx contains the FSM, address counter and sample register.

Verification
Bench parameters: CLK_FREQ=1000, BAUD=100 (10 clks/bit), ADDR_W=3, DATA_W=12. The RAM model returns 12'hA00+addr one cycle after rd_en.
REQ-030 Single dump: start 0->1 -> bytes A5, 0A 00, 0A 01, ..., 0A 07 (17 bytes); done pulses once; busy=0 after.
REQ-031 Bit timing: transmit byte 0xA5 -> tx low 10 cycles, then bits 1,0,1,0,0,1,0,1 each 10 cycles, then high 10 cycles.
REQ-032 Retrigger during a dump: pulse start again at byte 5 -> exactly 17 bytes and one done; no second frame.
REQ-033 Stuck-high start: start held high through the end of the dump -> no second frame; toggling 0->1 afterwards starts a new 17-byte frame.
REQ-034 Reset mid-frame: assert areset during data bit 3 of byte 4 -> tx=1 within the same cycle, busy=0, rd_addr=0; a new start then produces a full, correct frame.
REQ-035 Data isolation: rd_data changes 2 cycles after RD_WAIT -> transmitted bytes match the latched value only.

Source files
------------

// File: rtl/adc_dump_tx_pkg.sv
// Shared types and constants for the capture-buffer UART dump block.
package adc_dump_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD_REQ,
    RD_WAIT,
    SEND_HI,
    SEND_LO,
    NEXT,
    FIN
  } dump_state_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // Bit period rounded to the nearest whole clock.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/adc_dump_tx_if.sv
// Capture-buffer read port: the dumper is master, the buffer is slave.
interface adc_dump_tx_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) ();

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_addr, output rd_en, input rd_data);
  modport slave  (input rd_addr, input rd_en, output rd_data);

endinterface

// File: rtl/adc_dump_tx_uart.sv
// 8N1 byte serializer. tx_done marks the last cycle of the stop bit so a
// tx_go in that same cycle chains the next byte with no idle gap.
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       tx_go,
  input  logic [7:0] tx_byte,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic [8:0]       shift;
  logic             busy;
  logic             bit_end;
  logic             byte_end;

  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign byte_end = busy && bit_end && (bit_cnt == 4'd9);
  assign tx_done  = byte_end;
  assign tx_busy  = busy;

  // bit_cnt 0 is the start bit, 1..8 data, 9 stop; a 1 is shifted in behind
  // the data so the stop bit falls out of the register naturally.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '1;
      tx       <= 1'b1;
    end else if (tx_go && (!busy || byte_end)) begin
      busy     <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= {1'b1, tx_byte};
      tx       <= 1'b0;
    end else if (busy) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          busy <= 1'b0;
          tx   <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          tx      <= shift[0];
          shift   <= {1'b1, shift[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/adc_dump_tx.sv
// Dumps the whole capture buffer over UART as a 0xA5 header followed by
// each sample as a zero-padded high byte and a low byte.
module adc_dump_tx
  import adc_dump_tx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 12
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 start,
  adc_dump_tx_if.master        bus,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  dump_state_t       state;
  logic              start_q;
  logic              start_edge;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [7:0]        sample_lo;
  logic              tx_go;
  logic [7:0]        tx_byte;
  logic              tx_busy;
  logic              tx_done;

  assign start_edge  = start && !start_q;
  assign bus.rd_addr = rd_addr;
  assign bus.rd_en   = rd_en;

  // The high byte goes straight from rd_data into the serializer on the same
  // edge that latches the low byte, so both halves come from one capture.
  always_comb begin
    tx_go   = 1'b0;
    tx_byte = sample_lo;
    unique case (state)
      IDLE: begin
        tx_go   = start_edge && !tx_busy;
        tx_byte = HDR_BYTE;
      end
      RD_WAIT: begin
        tx_go   = 1'b1;
        tx_byte = 8'(bus.rd_data >> 8);
      end
      SEND_HI: tx_go = tx_done;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      start_q   <= start;
      rd_addr   <= '0;
      rd_en     <= 1'b0;
      sample_lo <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_edge && !tx_busy) begin
            state <= HDR;
            busy  <= 1'b1;
          end
        end
        HDR: begin
          if (tx_done) begin
            state <= RD_REQ;
            rd_en <= 1'b1;
          end
        end
        RD_REQ: begin
          rd_en <= 1'b0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          sample_lo <= bus.rd_data[7:0];
          state     <= SEND_HI;
        end
        SEND_HI: begin
          if (tx_done) state <= SEND_LO;
        end
        SEND_LO: begin
          if (tx_done) begin
            state <= NEXT;
            if (rd_addr == LAST_ADDR) busy <= 1'b0;
          end
        end
        NEXT: begin
          if (rd_addr == LAST_ADDR) begin
            state   <= FIN;
            done    <= 1'b1;
            rd_addr <= '0;
          end else begin
            state   <= RD_REQ;
            rd_addr <= rd_addr + 1'b1;
            rd_en   <= 1'b1;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk    (clk),
    .areset (areset),
    .tx_go  (tx_go),
    .tx_byte(tx_byte),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx     (tx)
  );

endmodule

// File: tb/tb_adc_dump_tx.sv
// Self-checking bench for adc_dump_tx: a UART receiver decodes tx and the
// bytes are compared with a frame built directly from the buffer contents.
module tb_adc_dump_tx;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 8;
  localparam int NBYTES = 1 + 2 * DEPTH;
  localparam int BITCLK = 10;

  logic clk;
  logic areset;
  logic start;
  logic tx;
  logic busy;
  logic done;

  int checks = 0;
  int failures = 0;

  adc_dump_tx_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  adc_dump_tx #(
    .CLK_FREQ(1000),
    .BAUD    (100),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk   (clk),
    .areset(areset),
    .start (start),
    .bus   (bus),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model with optional corruption of rd_data two cycles after it is valid.
  logic [DATA_W-1:0] mem [DEPTH];
  bit corrupt_en = 1'b0;
  int glitch_cnt = 0;
  always @(posedge clk) begin
    if (bus.rd_en === 1'b1) begin
      bus.rd_data <= mem[bus.rd_addr];
      glitch_cnt  <= 2;
    end else if (glitch_cnt != 0) begin
      glitch_cnt <= glitch_cnt - 1;
      if (glitch_cnt == 1 && corrupt_en) bus.rd_data <= ~bus.rd_data;
    end
  end

  // UART receiver, sampling mid-bit on the falling clock edge.
  logic [7:0] rx_q [$];
  int byte_start_q [$];
  bit rx_active = 1'b0;
  int rx_cnt = 0;
  logic [7:0] rx_shift;
  int framing_err = 0;
  int done_count = 0;
  int rd_en_count = 0;
  always @(negedge clk) begin
    if (areset) begin
      rx_active <= 1'b0;
    end else begin
      if (done === 1'b1) done_count <= done_count + 1;
      if (bus.rd_en === 1'b1) rd_en_count <= rd_en_count + 1;
      if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active <= 1'b1;
          rx_cnt    <= 1;
          byte_start_q.push_back(cyc);
        end
      end else begin
        rx_cnt <= rx_cnt + 1;
        if (rx_cnt == 5 && tx !== 1'b0) framing_err <= framing_err + 1;
        for (int k = 0; k < 8; k++)
          if (rx_cnt == BITCLK * (k + 1) + 5) rx_shift[k] <= tx;
        if (rx_cnt == 95) begin
          rx_active <= 1'b0;
          if (tx !== 1'b1) framing_err <= framing_err + 1;
          rx_q.push_back(rx_shift);
        end
      end
    end
  end

  logic [7:0] exp_q [$];

  function automatic void fill_mem(input bit ramp);
    for (int a = 0; a < DEPTH; a++)
      mem[a] = ramp ? (12'hA00 + 12'(a)) : 12'($urandom);
  endfunction

  // Expected frame: header, then each sample split into high and low bytes.
  function automatic void build_expected();
    int v;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int a = 0; a < DEPTH; a++) begin
      v = int'(mem[a]);
      exp_q.push_back(8'((v / 256) % 256));
      exp_q.push_back(8'(v % 256));
    end
  endfunction

  task automatic kick();
    start = 1'b0;
    repeat ($urandom_range(2, 6)) @(negedge clk);
    start = 1'b1;
  endtask

  task automatic wait_done(input int d0, input int budget, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < budget && timeout; i++) begin
      @(negedge clk);
      if (done_count > d0) timeout = 1'b0;
    end
  endtask

  task automatic wait_rx(input int n, input int budget, output bit timeout);
    timeout = 1'b1;
    for (int i = 0; i < budget && timeout; i++) begin
      @(negedge clk);
      if (rx_q.size() >= n) timeout = 1'b0;
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    start  = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (bus.rd_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_en got=%b exp=0", bus.rd_en); end
    checks++; if (bus.rd_addr !== 3'd0) begin failures++; $display("[TB] FAIL reset_rd_addr got=%0d exp=0", bus.rd_addr); end
    areset = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_dump();
    int base, d0, r0, idle;
    bit to;
    logic [7:0] got;
    fill_mem(1'b1);
    build_expected();
    base = rx_q.size(); d0 = done_count; r0 = rd_en_count;
    kick();
    wait_done(d0, 4000, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL single_timeout got=no_done exp=done"); end
    repeat (300) @(negedge clk);
    checks++; if (rx_q.size() - base != NBYTES) begin failures++; $display("[TB] FAIL single_len got=%0d exp=%0d", rx_q.size() - base, NBYTES); end
    for (int i = 0; i < NBYTES; i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("[TB] FAIL single_byte%0d got=%02h exp=%02h", i, got, exp_q[i]); end
    end
    for (int i = 1; i < NBYTES && base + i < byte_start_q.size(); i++) begin
      idle = byte_start_q[base + i] - byte_start_q[base + i - 1] - BITCLK * 10;
      checks++;
      if ((i % 2 == 0 && idle != 0) || idle < 0 || idle > 3) begin
        failures++; $display("[TB] FAIL single_gap%0d got=%0d exp=%s", i, idle, (i % 2 == 0) ? "0" : "0..3");
      end
    end
    checks++; if (done_count - d0 != 1) begin failures++; $display("[TB] FAIL single_done_pulses got=%0d exp=1", done_count - d0); end
    checks++; if (rd_en_count - r0 != DEPTH) begin failures++; $display("[TB] FAIL single_rd_en got=%0d exp=%0d", rd_en_count - r0, DEPTH); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_after got=%b exp=0", busy); end
    checks++; if (bus.rd_addr !== 3'd0) begin failures++; $display("[TB] FAIL single_addr_after got=%0d exp=0", bus.rd_addr); end
    checks++; if (framing_err != 0) begin failures++; $display("[TB] FAIL framing got=%0d exp=0", framing_err); end
  endtask

  task automatic test_bit_timing();
    int d0;
    bit to;
    logic exp_bit;
    logic [7:0] hdr;
    hdr = 8'hA5;
    fill_mem(1'b0);
    d0 = done_count;
    kick();
    to = 1'b1;
    for (int i = 0; i < 50 && to; i++) begin
      @(negedge clk);
      if (tx === 1'b0) to = 1'b0;
    end
    checks++; if (to) begin failures++; $display("[TB] FAIL timing_start got=no_start_bit exp=start_bit"); end
    for (int i = 0; i < 10 * BITCLK; i++) begin
      if (i / BITCLK == 0) exp_bit = 1'b0;
      else if (i / BITCLK == 9) exp_bit = 1'b1;
      else exp_bit = hdr[i / BITCLK - 1];
      checks++; if (tx !== exp_bit) begin failures++; $display("[TB] FAIL timing_cycle%0d got=%b exp=%b", i, tx, exp_bit); end
      @(negedge clk);
    end
    wait_done(d0, 4000, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL timing_done got=no_done exp=done"); end
  endtask

  task automatic test_retrigger();
    int base, d0;
    bit to;
    logic [7:0] got;
    fill_mem(1'b0);
    build_expected();
    base = rx_q.size(); d0 = done_count;
    kick();
    wait_rx(base + 5, 2000, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL retrig_reach got=%0d exp=5", rx_q.size() - base); end
    start = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    start = 1'b1;
    wait_done(d0, 4000, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL retrig_timeout got=no_done exp=done"); end
    repeat (300) @(negedge clk);
    checks++; if (rx_q.size() - base != NBYTES) begin failures++; $display("[TB] FAIL retrig_len got=%0d exp=%0d", rx_q.size() - base, NBYTES); end
    checks++; if (done_count - d0 != 1) begin failures++; $display("[TB] FAIL retrig_done got=%0d exp=1", done_count - d0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL retrig_busy got=%b exp=0", busy); end
    for (int i = 0; i < NBYTES; i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("[TB] FAIL retrig_byte%0d got=%02h exp=%02h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_stuck_high();
    int base, d0;
    bit to;
    logic [7:0] got;
    fill_mem(1'b0);
    build_expected();
    base = rx_q.size(); d0 = done_count;
    kick();
    wait_done(d0, 4000, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL stuck_timeout got=no_done exp=done"); end
    repeat (300) @(negedge clk);
    checks++; if (rx_q.size() - base != NBYTES) begin failures++; $display("[TB] FAIL stuck_len got=%0d exp=%0d", rx_q.size() - base, NBYTES); end
    checks++; if (done_count - d0 != 1) begin failures++; $display("[TB] FAIL stuck_done got=%0d exp=1", done_count - d0); end
    fill_mem(1'b0);
    build_expected();
    base = rx_q.size(); d0 = done_count;
    kick();
    wait_done(d0, 4000, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL stuck_rearm got=no_done exp=done"); end
    repeat (20) @(negedge clk);
    checks++; if (rx_q.size() - base != NBYTES) begin failures++; $display("[TB] FAIL stuck_rearm_len got=%0d exp=%0d", rx_q.size() - base, NBYTES); end
    for (int i = 0; i < NBYTES; i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("[TB] FAIL stuck_byte%0d got=%02h exp=%02h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int base, d0;
    bit to;
    logic [7:0] got;
    fill_mem(1'b0);
    base = rx_q.size();
    kick();
    wait_rx(base + 4, 2000, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL midrst_reach got=%0d exp=4", rx_q.size() - base); end
    to = 1'b1;
    for (int i = 0; i < 50 && to; i++) begin
      @(negedge clk);
      if (tx === 1'b0) to = 1'b0;
    end
    checks++; if (to) begin failures++; $display("[TB] FAIL midrst_byte4 got=no_start_bit exp=start_bit"); end
    repeat (4 * BITCLK + 5) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL midrst_busy_before got=%b exp=1", busy); end
    areset = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("[TB] FAIL midrst_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (bus.rd_addr !== 3'd0) begin failures++; $display("[TB] FAIL midrst_addr got=%0d exp=0", bus.rd_addr); end
    repeat (3) @(negedge clk);
    areset = 1'b0;
    base = rx_q.size();
    repeat (60) @(negedge clk);
    checks++; if (busy !== 1'b0 || rx_q.size() != base) begin failures++; $display("[TB] FAIL midrst_no_auto got=busy%b_bytes%0d exp=busy0_bytes0", busy, rx_q.size() - base); end
    fill_mem(1'b0);
    build_expected();
    d0 = done_count;
    kick();
    wait_done(d0, 4000, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL midrst_timeout got=no_done exp=done"); end
    repeat (20) @(negedge clk);
    checks++; if (rx_q.size() - base != NBYTES) begin failures++; $display("[TB] FAIL midrst_len got=%0d exp=%0d", rx_q.size() - base, NBYTES); end
    for (int i = 0; i < NBYTES; i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("[TB] FAIL midrst_byte%0d got=%02h exp=%02h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_data_isolation();
    int base, d0;
    bit to;
    logic [7:0] got;
    fill_mem(1'b0);
    build_expected();
    corrupt_en = 1'b1;
    base = rx_q.size(); d0 = done_count;
    kick();
    wait_done(d0, 4000, to);
    checks++; if (to) begin failures++; $display("[TB] FAIL iso_timeout got=no_done exp=done"); end
    repeat (20) @(negedge clk);
    corrupt_en = 1'b0;
    checks++; if (rx_q.size() - base != NBYTES) begin failures++; $display("[TB] FAIL iso_len got=%0d exp=%0d", rx_q.size() - base, NBYTES); end
    for (int i = 0; i < NBYTES; i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("[TB] FAIL iso_byte%0d got=%02h exp=%02h", i, got, exp_q[i]); end
    end
    checks++; if (framing_err != 0) begin failures++; $display("[TB] FAIL iso_framing got=%0d exp=0", framing_err); end
  endtask

  initial begin
    areset = 1'b1;
    start  = 1'b0;
    test_reset();
    test_single_dump();
    test_bit_timing();
    test_retrigger();
    test_stuck_high();
    test_reset_mid_frame();
    test_data_isolation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
